flopr_pipe: RTL and testbench

//   Parametrised DEPTH-stage register pipeline; the multi-stage successor of

---
 rtl/flopr_pipe_if.sv | 27 ++
 rtl/flopr_en.sv | 23 ++
 rtl/flopr_pipe.sv | 98 +++++++++
 tb/tb_flopr_pipe.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flopr_pipe_if.sv
// Handshake/data bundle for flopr_pipe: the master drives the stage inputs and
// the slave (the pipeline) returns the last stage and the occupancy count.
interface flopr_pipe_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             i_en;
    logic             i_flush;
    logic             i_valid;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] o_y;
    logic             o_valid;
    logic [CW-1:0]    o_count;
    logic             o_busy;

    modport master (
        output i_en, i_flush, i_valid, i_a,
        input  o_y, o_valid, o_count, o_busy
    );

    modport slave (
        input  i_en, i_flush, i_valid, i_a,
        output o_y, o_valid, o_count, o_busy
    );
endinterface

// File: rtl/flopr_en.sv
// Enabled register with synchronous clear to a parameterised value; one
// pipeline stage (or one half of a stage) of flopr_pipe.
module flopr_en #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             i_sclr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_sclr)
            r_q <= RESET_VAL;
        else if (i_en)
            r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

// File: rtl/flopr_pipe.sv
// DEPTH-stage {valid,data} register pipeline with stall, synchronous clear,
// valid-only flush, optional data gating and a registered occupancy counter.
module flopr_pipe #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               GATE_DATA = 1'b0
) (
    input  logic           clk,
    input  logic           i_sclr,
    flopr_pipe_if.slave    bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] w_data [DEPTH];
    logic             w_vld  [DEPTH];
    logic             w_adv;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_count_next;
    logic             r_busy;

    // Flush wins over advance; clear is applied inside every stage register.
    assign w_adv = bus.i_en & ~bus.i_flush;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] w_src_data;
        logic             w_src_vld;

        if (gi == 0) begin : g_first
            assign w_src_data = bus.i_a;
            assign w_src_vld  = bus.i_valid;
        end else begin : g_next
            assign w_src_data = w_data[gi-1];
            assign w_src_vld  = w_vld[gi-1];
        end

        if (GATE_DATA) begin : g_gated
            logic w_vld_d;
            assign w_vld_d = w_src_vld & ~bus.i_flush;

            flopr_en #(.WIDTH(1), .RESET_VAL(1'b0)) u_vld (
                .clk    (clk),
                .i_sclr (i_sclr),
                .i_en   (w_adv | bus.i_flush),
                .i_d    (w_vld_d),
                .o_q    (w_vld[gi])
            );

            flopr_en #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_data (
                .clk    (clk),
                .i_sclr (i_sclr),
                .i_en   (w_adv & w_src_vld),
                .i_d    (w_src_data),
                .o_q    (w_data[gi])
            );
        end else begin : g_plain
            logic [WIDTH:0] w_d;
            logic [WIDTH:0] w_q;

            // On flush the stage reloads its own data with valid cleared.
            assign w_d = bus.i_flush ? {1'b0, w_data[gi]} : {w_src_vld, w_src_data};

            flopr_en #(.WIDTH(WIDTH + 1), .RESET_VAL({1'b0, RESET_VAL})) u_stage (
                .clk    (clk),
                .i_sclr (i_sclr),
                .i_en   (w_adv | bus.i_flush),
                .i_d    (w_d),
                .o_q    (w_q)
            );

            assign w_vld[gi]  = w_q[WIDTH];
            assign w_data[gi] = w_q[WIDTH-1:0];
        end
    end

    // Occupancy tracks the valid entering stage 0 against the one leaving.
    always_comb begin
        r_count_next = r_count;
        if (i_sclr || bus.i_flush) begin
            r_count_next = '0;
        end else if (bus.i_en) begin
            if (bus.i_valid && !w_vld[DEPTH-1])
                r_count_next = r_count + CW'(1);
            else if (!bus.i_valid && w_vld[DEPTH-1])
                r_count_next = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        r_count <= r_count_next;
        r_busy  <= (r_count_next != '0);
    end

    assign bus.o_y     = w_data[DEPTH-1];
    assign bus.o_valid = w_vld[DEPTH-1];
    assign bus.o_count = r_count;
    assign bus.o_busy  = r_busy;
endmodule

// File: tb/tb_flopr_pipe.sv
// Directed bench for flopr_pipe: default, data-gated and single-stage builds
// share one stimulus; a valid-bit shadow checks o_count every cycle.
module tb_flopr_pipe;
    logic        clk = 1'b0;
    logic        sclr = 1'b0;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] a = '0;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    logic m_v [3];

    always #5 clk = ~clk;

    flopr_pipe_if #(.WIDTH(32), .DEPTH(3)) ifa ();
    flopr_pipe_if #(.WIDTH(32), .DEPTH(3)) ifg ();
    flopr_pipe_if #(.WIDTH(32), .DEPTH(1)) if1 ();

    assign ifa.i_en = en;  assign ifa.i_flush = flush;  assign ifa.i_valid = valid;  assign ifa.i_a = a;
    assign ifg.i_en = en;  assign ifg.i_flush = flush;  assign ifg.i_valid = valid;  assign ifg.i_a = a;
    assign if1.i_en = en;  assign if1.i_flush = flush;  assign if1.i_valid = valid;  assign if1.i_a = a;

    flopr_pipe #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'h0), .GATE_DATA(1'b0)) dut_a (
        .clk(clk), .i_sclr(sclr), .bus(ifa.slave));
    flopr_pipe #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'h0), .GATE_DATA(1'b1)) dut_g (
        .clk(clk), .i_sclr(sclr), .bus(ifg.slave));
    flopr_pipe #(.WIDTH(32), .DEPTH(1), .RESET_VAL(32'hFFFF_FFFF), .GATE_DATA(1'b0)) dut_1 (
        .clk(clk), .i_sclr(sclr), .bus(if1.slave));

    // Shadow of the DEPTH=3 valid chain, driven only by the bench inputs.
    always @(posedge clk) begin
        if (sclr || flush) begin
            m_v[0] <= 1'b0; m_v[1] <= 1'b0; m_v[2] <= 1'b0;
        end else if (en) begin
            m_v[0] <= valid; m_v[1] <= m_v[0]; m_v[2] <= m_v[1];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int pc;
            pc = int'(m_v[0]) + int'(m_v[1]) + int'(m_v[2]);
            n_tests++;
            if (int'(ifa.o_count) !== pc || ifa.o_valid !== m_v[2] || ifa.o_busy !== (pc != 0)) begin
                n_fail++;
                $display("[TB] FAIL inv_a: count=%0d valid=%b busy=%b, required count=%0d valid=%b",
                         ifa.o_count, ifa.o_valid, ifa.o_busy, pc, m_v[2]);
            end
            n_tests++;
            if (int'(ifg.o_count) !== pc || ifg.o_valid !== m_v[2] || ifg.o_busy !== (pc != 0)) begin
                n_fail++;
                $display("[TB] FAIL inv_g: count=%0d valid=%b busy=%b, required count=%0d valid=%b",
                         ifg.o_count, ifg.o_valid, ifg.o_busy, pc, m_v[2]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        $display("[TB] t=%0t sclr=%b flush=%b en=%b v=%b a=%h | y=%h v=%b cnt=%0d | yg=%h | y1=%h v1=%b",
                 $time, sclr, flush, en, valid, a, ifa.o_y, ifa.o_valid, ifa.o_count,
                 ifg.o_y, if1.o_y, if1.o_valid);
    endtask

    task automatic do_reset();
        sclr = 1'b1; en = 1'b0; flush = 1'b0; valid = 1'b0; a = '0;
        step();
        sclr = 1'b0;
    endtask

    task automatic test_reset();
        sclr = 1'b1; en = 1'b1; valid = 1'b1; a = 32'hDEAD_BEEF; flush = 1'b0;
        step();
        sclr = 1'b0; en = 1'b0; valid = 1'b0;
        n_tests++;
        if (ifa.o_y !== 32'h0 || ifa.o_valid !== 1'b0 || ifa.o_count !== 2'd0 || ifa.o_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset: y=%h v=%b cnt=%0d busy=%b, required 0/0/0/0",
                     ifa.o_y, ifa.o_valid, ifa.o_count, ifa.o_busy);
        end
        n_tests++;
        if (if1.o_y !== 32'hFFFF_FFFF || if1.o_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_d1: y=%h v=%b, required ffffffff/0", if1.o_y, if1.o_valid);
        end
        chk_en = 1'b1;
    endtask

    task automatic test_latency();
        logic [31:0] exp_y [3];
        int          exp_c [3];
        exp_y[0] = 32'd1; exp_y[1] = 32'd2; exp_y[2] = 32'd3;
        exp_c[0] = 3;     exp_c[1] = 2;     exp_c[2] = 1;
        do_reset();
        en = 1'b1; valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            a = 32'(i);
            step();
            if (i < 3) begin
                n_tests++;
                if (ifa.o_valid !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL latency_early%0d: v=%b, required 0", i, ifa.o_valid);
                end
            end
            valid = (i < 3);
        end
        valid = 1'b0; a = '0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (ifa.o_y !== exp_y[i] || ifa.o_valid !== 1'b1 || int'(ifa.o_count) !== exp_c[i]) begin
                n_fail++;
                $display("[TB] FAIL latency%0d: y=%h v=%b cnt=%0d, required %h/1/%0d",
                         i, ifa.o_y, ifa.o_valid, ifa.o_count, exp_y[i], exp_c[i]);
            end
            step();
        end
        n_tests++;
        if (ifa.o_valid !== 1'b0 || ifa.o_count !== 2'd0) begin
            n_fail++;
            $display("[TB] FAIL latency_drain: v=%b cnt=%0d, required 0/0", ifa.o_valid, ifa.o_count);
        end
        en = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        en = 1'b1; valid = 1'b1;
        for (int i = 5; i <= 7; i++) begin
            a = 32'(i);
            step();
        end
        en = 1'b0; valid = 1'bx; a = 'x;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (ifa.o_y !== 32'd5 || ifa.o_count !== 2'd3 || ifa.o_valid !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL stall%0d: y=%h cnt=%0d v=%b, required 5/3/1",
                         i, ifa.o_y, ifa.o_count, ifa.o_valid);
            end
        end
        en = 1'b1; valid = 1'b0; a = '0;
        step();
        n_tests++;
        if (ifa.o_y !== 32'd6 || ifa.o_count !== 2'd2) begin
            n_fail++;
            $display("[TB] FAIL stall_resume6: y=%h cnt=%0d, required 6/2", ifa.o_y, ifa.o_count);
        end
        step();
        n_tests++;
        if (ifa.o_y !== 32'd7 || ifa.o_count !== 2'd1) begin
            n_fail++;
            $display("[TB] FAIL stall_resume7: y=%h cnt=%0d, required 7/1", ifa.o_y, ifa.o_count);
        end
        en = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        en = 1'b1; valid = 1'b1;
        for (int i = 10; i <= 12; i++) begin
            a = 32'(i);
            step();
        end
        flush = 1'b1; a = 32'h0000_000D;
        step();
        flush = 1'b0; en = 1'b0;
        n_tests++;
        if (ifa.o_y !== 32'h0A || ifa.o_valid !== 1'b0 || ifa.o_count !== 2'd0) begin
            n_fail++;
            $display("[TB] FAIL flush: y=%h v=%b cnt=%0d, required 0a/0/0", ifa.o_y, ifa.o_valid, ifa.o_count);
        end
        n_tests++;
        if (ifg.o_y !== 32'h0A || ifg.o_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_g: y=%h v=%b, required 0a/0", ifg.o_y, ifg.o_valid);
        end
        en = 1'b1; valid = 1'b1;
        for (int i = 10; i <= 12; i++) begin
            a = 32'(i);
            step();
        end
        sclr = 1'b1; flush = 1'b1;
        step();
        sclr = 1'b0; flush = 1'b0; en = 1'b0;
        n_tests++;
        if (ifa.o_y !== 32'h0 || ifa.o_valid !== 1'b0 || ifa.o_count !== 2'd0) begin
            n_fail++;
            $display("[TB] FAIL flush_sclr: y=%h v=%b cnt=%0d, required 0/0/0", ifa.o_y, ifa.o_valid, ifa.o_count);
        end
    endtask

    task automatic test_bubbles();
        logic [31:0] exp_y  [3];
        logic [31:0] exp_yg [3];
        logic        exp_v  [3];
        exp_y[0]  = 32'd10; exp_y[1]  = 32'd99; exp_y[2]  = 32'd12;
        exp_yg[0] = 32'd10; exp_yg[1] = 32'd10; exp_yg[2] = 32'd12;
        exp_v[0]  = 1'b1;   exp_v[1]  = 1'b0;   exp_v[2]  = 1'b1;
        do_reset();
        en = 1'b1;
        valid = 1'b1; a = 32'd10; step();
        valid = 1'b0; a = 32'd99; step();
        valid = 1'b1; a = 32'd12; step();
        valid = 1'b0; a = 32'd0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (ifa.o_y !== exp_y[i] || ifa.o_valid !== exp_v[i] || ifa.o_count > 2'd2) begin
                n_fail++;
                $display("[TB] FAIL bubble%0d: y=%h v=%b cnt=%0d, required %h/%b/<=2",
                         i, ifa.o_y, ifa.o_valid, ifa.o_count, exp_y[i], exp_v[i]);
            end
            n_tests++;
            if (ifg.o_y !== exp_yg[i] || ifg.o_valid !== exp_v[i]) begin
                n_fail++;
                $display("[TB] FAIL bubble_g%0d: y=%h v=%b, required %h/%b",
                         i, ifg.o_y, ifg.o_valid, exp_yg[i], exp_v[i]);
            end
            step();
        end
        en = 1'b0;
    endtask

    task automatic test_depth1();
        do_reset();
        n_tests++;
        if (if1.o_y !== 32'hFFFF_FFFF || if1.o_valid !== 1'b0 || if1.o_count !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL d1_reset: y=%h v=%b cnt=%0d, required ffffffff/0/0",
                     if1.o_y, if1.o_valid, if1.o_count);
        end
        en = 1'b1; valid = 1'b1; a = 32'd1;
        step();
        en = 1'b0; valid = 1'b0;
        n_tests++;
        if (if1.o_y !== 32'd1 || if1.o_valid !== 1'b1 || if1.o_count !== 1'b1 || if1.o_busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL d1_load: y=%h v=%b cnt=%0d busy=%b, required 1/1/1/1",
                     if1.o_y, if1.o_valid, if1.o_count, if1.o_busy);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_latency();
        test_stall();
        test_flush();
        test_bubbles();
        test_depth1();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
